// File: rtl/iter_div_pkg.sv
// Shared definitions for the iterative radix-2 divider: FSM states, div_op
// bit positions, iteration count, special-case constants and the result
// sign/select helper used by both the full and the short-cut paths.
package iter_div_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } div_state_e;

  localparam int          DIV_OP_MOD = 0;
  localparam int          DIV_OP_UNS = 1;
  localparam int          DIV_ITERS  = 32;
  localparam logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN    = 32'h8000_0000;

  // Apply the operand-derived signs to the unsigned quotient/remainder and
  // pick the one the instruction asked for. A zero divisor forces the
  // all-ones quotient regardless of sign; the remainder still comes back as
  // the original dividend because its magnitude passes through untouched.
  function automatic logic [31:0] div_finalize(
    input logic [31:0] q_mag,
    input logic [31:0] r_mag,
    input logic        q_neg,
    input logic        r_neg,
    input logic        div_zero,
    input logic        is_mod
  );
    logic [31:0] q_val;
    logic [31:0] r_val;
    q_val = div_zero ? DIV_ZERO_Q : (q_neg ? (~q_mag + 32'd1) : q_mag);
    r_val = r_neg ? (~r_mag + 32'd1) : r_mag;
    return is_mod ? r_val : q_val;
  endfunction

endpackage

// File: rtl/iter_div_step.sv
// One combinational restoring-division step: shift the next dividend bit
// into the partial remainder, trial-subtract the divisor, keep or restore.
module iter_div_step
  import iter_div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] dsr_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             qbit_o
);

  logic [WIDTH:0] trial;

  // The partial remainder is always below the divisor, so the shifted value
  // is below twice the divisor and the top bit of the trial difference is a
  // reliable borrow/sign flag.
  always_comb begin
    trial  = {rem_i, bit_i} - {1'b0, dsr_i};
    qbit_o = ~trial[WIDTH];
    rem_o  = trial[WIDTH] ? {rem_i[WIDTH-2:0], bit_i} : trial[WIDTH-1:0];
  end

endmodule

// File: rtl/iter_div.sv
// Iterative radix-2 restoring divider for DIV.W / MOD.W / DIV.WU / MOD.WU.
// Optional build macro: DIV_FAST_ZERO_EN -- when defined, a zero divisor or a
// dividend magnitude below the divisor magnitude skips the iteration and the
// result is registered straight from IDLE.
module iter_div
  import iter_div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             div_valid,
  output logic             div_ready,
  input  logic [1:0]       div_op,
  input  logic [WIDTH-1:0] div_src1,
  input  logic [WIDTH-1:0] div_src2,
  input  logic             flush,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] div_result,
  output logic             busy
);

  localparam int             CNT_W     = $clog2(DIV_ITERS);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DIV_ITERS - 1);

  div_state_e       state_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] dsr_q;
  logic [WIDTH-1:0] res_q;
  logic [CNT_W-1:0] cnt_q;
  logic             qneg_q;
  logic             rneg_q;
  logic             mod_q;
  logic             res_valid_q;

  logic             is_signed;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] rem_d;
  logic [WIDTH-1:0] quo_d;
  logic             qbit_d;

  // Operand magnitudes and signs for the request currently on the inputs.
  always_comb begin
    is_signed = ~div_op[DIV_OP_UNS];
    a_neg     = is_signed & |(div_src1 & INT_MIN);
    b_neg     = is_signed & |(div_src2 & INT_MIN);
    a_mag     = a_neg ? (~div_src1 + 1'b1) : div_src1;
    b_mag     = b_neg ? (~div_src2 + 1'b1) : div_src2;
  end

  // The quotient register doubles as the dividend shift register: its MSB
  // feeds the step and the new quotient bit enters at the LSB.
  iter_div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i  (rem_q),
    .bit_i  (quo_q[WIDTH-1]),
    .dsr_i  (dsr_q),
    .rem_o  (rem_d),
    .qbit_o (qbit_d)
  );

  assign quo_d = {quo_q[WIDTH-2:0], qbit_d};

`ifdef DIV_FAST_ZERO_EN
  logic skip_calc;
  assign skip_calc = (b_mag == '0) || (a_mag < b_mag);
`endif

  // Divider FSM with registered result and result-valid.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      quo_q       <= '0;
      rem_q       <= '0;
      dsr_q       <= '0;
      res_q       <= '0;
      cnt_q       <= '0;
      qneg_q      <= 1'b0;
      rneg_q      <= 1'b0;
      mod_q       <= 1'b0;
      res_valid_q <= 1'b0;
    end else if (flush) begin
      state_q     <= S_IDLE;
      res_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (div_valid) begin
            quo_q  <= a_mag;
            rem_q  <= '0;
            dsr_q  <= b_mag;
            qneg_q <= a_neg ^ b_neg;
            rneg_q <= a_neg;
            mod_q  <= div_op[DIV_OP_MOD];
            cnt_q  <= '0;
`ifdef DIV_FAST_ZERO_EN
            if (skip_calc) begin
              state_q     <= S_DONE;
              res_q       <= div_finalize('0, a_mag, a_neg ^ b_neg, a_neg,
                                          b_mag == '0, div_op[DIV_OP_MOD]);
              res_valid_q <= 1'b1;
            end else begin
              state_q <= S_CALC;
            end
`else
            state_q <= S_CALC;
`endif
          end
        end
        S_CALC: begin
          quo_q <= quo_d;
          rem_q <= rem_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST_ITER) begin
            state_q     <= S_DONE;
            res_q       <= div_finalize(quo_d, rem_d, qneg_q, rneg_q,
                                        dsr_q == '0, mod_q);
            res_valid_q <= 1'b1;
          end
        end
        S_DONE: begin
          if (res_ready) begin
            state_q     <= S_IDLE;
            res_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          res_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign div_ready  = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign res_valid  = res_valid_q;
  assign div_result = res_q;

endmodule

// File: tb/tb_iter_div.sv
// Directed bench for iter_div: hand-computed quotient/remainder vectors,
// latency, back-pressure, flush and mid-operation reset.
module tb_iter_div;

  logic        clk;
  logic        resetn;
  logic        div_valid;
  logic        div_ready;
  logic [1:0]  div_op;
  logic [31:0] div_src1;
  logic [31:0] div_src2;
  logic        flush;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] div_result;
  logic        busy;

  int n_pass  = 0;
  int n_total = 0;

`ifdef DIV_FAST_ZERO_EN
  localparam int ZLAT = 1;
`else
  localparam int ZLAT = 33;
`endif
  localparam int FLAT = 33;

  iter_div #(.WIDTH(32)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .div_valid  (div_valid),
    .div_ready  (div_ready),
    .div_op     (div_op),
    .div_src1   (div_src1),
    .div_src2   (div_src2),
    .flush      (flush),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .div_result (div_result),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request with res_ready held high; measure latency counting the
  // acceptance edge as cycle 0, so res_valid seen after edge N is cycle N+1.
  task automatic run_op(input string tag, input logic [1:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input int exp_lat);
    int lat;
    int guard;
    guard = 0;
    while (!div_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    div_op    = op;
    div_src1  = a;
    div_src2  = b;
    div_valid = 1'b1;
    res_ready = 1'b1;
    @(posedge clk); #1;
    div_valid = 1'b0;
    lat = 1;
    while (!res_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, " result"}, div_result, exp_res);
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    @(posedge clk); #1;
  endtask

  initial begin
    int  lat;
    logic seen;

    resetn    = 1'b0;
    div_valid = 1'b0;
    div_op    = 2'b00;
    div_src1  = '0;
    div_src2  = '0;
    flush     = 1'b0;
    res_ready = 1'b0;

    #12;
    check("rst div_ready",  32'(div_ready),  32'd1);
    check("rst res_valid",  32'(res_valid),  32'd0);
    check("rst busy",       32'(busy),       32'd0);
    check("rst div_result", div_result,      32'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk); #1;

    run_op("div.w 7/-2",       2'b00, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, FLAT);
    run_op("mod.w 7/-2",       2'b01, 32'd7,          32'hFFFF_FFFE, 32'h0000_0001, FLAT);
    run_op("div.wu ffff/16",   2'b10, 32'hFFFF_FFFF,  32'h10,        32'h0FFF_FFFF, FLAT);
    run_op("mod.wu ffff/16",   2'b11, 32'hFFFF_FFFF,  32'h10,        32'h0000_000F, FLAT);
    run_op("mod.w -7/2",       2'b01, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, FLAT);
    run_op("div.w min/-1",     2'b00, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, FLAT);
    run_op("mod.w min/-1",     2'b01, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, FLAT);
    run_op("div.w 5/0",        2'b00, 32'd5,          32'd0,         32'hFFFF_FFFF, ZLAT);
    run_op("mod.w 5/0",        2'b01, 32'd5,          32'd0,         32'h0000_0005, ZLAT);
    run_op("div.w -5/0",       2'b00, 32'hFFFF_FFFB,  32'd0,         32'hFFFF_FFFF, ZLAT);
    run_op("mod.w -5/0",       2'b01, 32'hFFFF_FFFB,  32'd0,         32'hFFFF_FFFB, ZLAT);
    run_op("div.wu 5/0",       2'b10, 32'd5,          32'd0,         32'hFFFF_FFFF, ZLAT);

    // Back-pressure: result must hold while res_ready is low.
    div_op    = 2'b10;
    div_src1  = 32'hFFFF_FFFF;
    div_src2  = 32'h10;
    div_valid = 1'b1;
    res_ready = 1'b0;
    @(posedge clk); #1;
    div_valid = 1'b0;
    lat = 1;
    while (!res_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check("bp latency", 32'(lat), 32'(FLAT));
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp res_valid",  32'(res_valid), 32'd1);
      check("bp div_result", div_result,     32'h0FFF_FFFF);
      check("bp div_ready",  32'(div_ready), 32'd0);
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    check("bp ready after hs", 32'(div_ready), 32'd1);
    check("bp valid after hs", 32'(res_valid), 32'd0);

    // Flush at CALC cycle 10.
    div_op    = 2'b00;
    div_src1  = 32'd7;
    div_src2  = 32'hFFFF_FFFE;
    div_valid = 1'b1;
    @(posedge clk); #1;
    div_valid = 1'b0;
    check("calc busy",      32'(busy),      32'd1);
    check("calc div_ready", 32'(div_ready), 32'd0);
    repeat (9) begin
      @(posedge clk); #1;
    end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush div_ready", 32'(div_ready), 32'd1);
    check("flush busy",      32'(busy),      32'd0);
    check("flush res_valid", 32'(res_valid), 32'd0);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      seen = seen | res_valid;
    end
    check("flush no result", 32'(seen), 32'd0);
    run_op("div.w 100/7", 2'b00, 32'd100, 32'd7, 32'd14, FLAT);

    // Asynchronous reset in the middle of CALC.
    div_op    = 2'b01;
    div_src1  = 32'd7;
    div_src2  = 32'hFFFF_FFFE;
    div_valid = 1'b1;
    @(posedge clk); #1;
    div_valid = 1'b0;
    repeat (15) begin
      @(posedge clk); #1;
    end
    #2;
    resetn = 1'b0;
    #1;
    check("mid rst div_ready",  32'(div_ready), 32'd1);
    check("mid rst res_valid",  32'(res_valid), 32'd0);
    check("mid rst busy",       32'(busy),      32'd0);
    check("mid rst div_result", div_result,     32'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk); #1;
    run_op("mod.w 100/7", 2'b01, 32'd100, 32'd7, 32'd2, FLAT);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
